// File: rtl/cpu_div_cell.sv
// Iterative restoring divider for div/divu: one quotient bit per clock,
// fixed data-independent latency so the stall controller can just count cycles.
module cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_signed,
  input  logic              E_div_start,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] dvd, dvs, prem, quo, raw1;
  logic              qneg, rneg, dz;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic [DATA_W:0]   shifted, trial;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic                    is_signed);
    logic [DATA_W-1:0] u;
    u = v;
    return (is_signed && v[DATA_W-1]) ? negate(u) : u;
  endfunction

  // The full partial remainder is kept so unsigned divisors above 2^(DATA_W-1) stay exact.
  always_comb begin
    shifted = {prem, dvd[DATA_W-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // A start is taken in IDLE and also on the DONE edge, allowing back-to-back issue.
  assign accept = E_div_start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (E_div_start) state_nxt = CALC;
      CALC:    if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = E_div_start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd        <= '0;
      dvs        <= '0;
      prem       <= '0;
      quo        <= '0;
      raw1       <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      dz         <= 1'b0;
      cnt        <= '0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
    end else begin
      case (state)
        CALC: begin
          dvd  <= {dvd[DATA_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (!trial[DATA_W]) begin
            prem <= trial[DATA_W-1:0];
            quo  <= {quo[DATA_W-2:0], 1'b1};
          end else begin
            prem <= shifted[DATA_W-1:0];
            quo  <= {quo[DATA_W-2:0], 1'b0};
          end
        end
        FIX: begin
          M_div_done <= 1'b1;
          if (dz) begin
            M_div_quot <= '1;
            M_div_rem  <= raw1;
          end else begin
            M_div_quot <= qneg ? negate(quo) : quo;
            M_div_rem  <= rneg ? negate(prem) : prem;
          end
        end
        DONE: begin
          M_div_done <= 1'b0;
          M_div_busy <= 1'b0;
        end
        default: ;
      endcase
      if (accept) begin
        dvd        <= magnitude(E_src1, E_div_signed);
        dvs        <= magnitude(E_src2, E_div_signed);
        qneg       <= E_div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
        rneg       <= E_div_signed & E_src1[DATA_W-1];
        raw1       <= E_src1;
        dz         <= (E_src2 == '0);
        prem       <= '0;
        quo        <= '0;
        cnt        <= '0;
        M_div_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_div_cell.sv
// Directed bench for cpu_div_cell: stimulus pushes expected results and done cycle,
// an independent monitor pops and compares whenever the divider pulses done.
module tb_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] E_src1 = '0;
  logic [31:0] E_src2 = '0;
  logic        E_div_signed = 1'b0;
  logic        E_div_start = 1'b0;
  logic        M_div_busy, M_div_done;
  logic [31:0] M_div_quot, M_div_rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cpu_div_cell #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .E_src1(E_src1), .E_src2(E_src2),
    .E_div_signed(E_div_signed), .E_div_start(E_div_start),
    .M_div_busy(M_div_busy), .M_div_done(M_div_done),
    .M_div_quot(M_div_quot), .M_div_rem(M_div_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && M_div_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", M_div_quot, e.q);
        chk("rem", M_div_rem, e.r);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // Drives start so it is sampled on the next rising edge k; returns at the negedge after k.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit push, input logic [31:0] eq, input logic [31:0] er);
    @(negedge clk);
    E_src1       = a;
    E_src2       = b;
    E_div_signed = s;
    E_div_start  = 1'b1;
    if (push) sb.push_back('{eq, er, cyc + 1 + 33});
    @(negedge clk);
    E_div_start  = 1'b0;
    E_src1       = $urandom;
    E_src2       = $urandom;
    E_div_signed = $urandom_range(0, 1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er);
    launch(a, b, s, 1'b1, eq, er);
    chk("busy_after_start", M_div_busy, 32'd1);
    repeat (33) @(negedge clk);
    chk("busy_in_done_cycle", M_div_busy, 32'd1);
    @(negedge clk);
    chk("busy_after_done", M_div_busy, 32'd0);
    chk("done_cleared", M_div_done, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", M_div_busy, 32'd0);
    chk("rst_done", M_div_done, 32'd0);
    chk("rst_quot", M_div_quot, 32'd0);
    chk("rst_rem", M_div_rem, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd100,       32'd7,         1'b0, 32'h0000000E, 32'h00000002);
    run(32'hFFFFFFF9,  32'h00000002,  1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run(32'h00000007,  32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD, 32'h00000001);
    run(32'h12345678,  32'h0,         1'b0, 32'hFFFFFFFF, 32'h12345678);
    run(32'h12345678,  32'h0,         1'b1, 32'hFFFFFFFF, 32'h12345678);
    run(32'hFFFFFFF0,  32'h0,         1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0);
    run(32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000, 32'h00000000);
    run(32'hFFFFFFFF,  32'h00000010,  1'b0, 32'h0FFFFFFF, 32'h0000000F);
    run(32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 32'h00000001, 32'h00000001);
    run(32'h80000000,  32'h80000001,  1'b0, 32'h00000000, 32'h80000000);
    run(32'hFFFFFF9C,  32'h00000007,  1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run(32'hFFFFFFF8,  32'hFFFFFFFD,  1'b1, 32'h00000002, 32'hFFFFFFFE);

    // Start during busy is ignored; start on the DONE edge is accepted back-to-back.
    launch(32'd100, 32'd7, 1'b0, 1'b1, 32'h0000000E, 32'h00000002);
    repeat (4) @(negedge clk);
    E_src1 = 32'd1000; E_src2 = 32'd10; E_div_signed = 1'b1; E_div_start = 1'b1;
    @(negedge clk);
    E_div_start = 1'b0;
    repeat (27) @(negedge clk);
    launch(32'hFFFFFF9C, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
    chk("busy_back_to_back", M_div_busy, 32'd1);
    repeat (33) @(negedge clk);
    @(negedge clk);
    chk("busy_after_b2b", M_div_busy, 32'd0);

    // Reset mid-operation: no done pulse, outputs cleared.
    launch(32'd5000, 32'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", M_div_busy, 32'd0);
    chk("midrst_quot", M_div_quot, 32'd0);
    chk("midrst_rem", M_div_rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("postrst_busy", M_div_busy, 32'd0);
    chk("postrst_done", M_div_done, 32'd0);
    chk("postrst_quot", M_div_quot, 32'd0);
    run(32'd5000, 32'd3, 1'b0, 32'd1666, 32'd2);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
